// File: rtl/bshift_pkg.sv
// Shared types and helpers for the bshift_arb shared-shifter arbiter.
// Optional build macro used by the arbiter: BSHIFT_ARB_RR_EN (round-robin vs fixed priority).
package bshift_pkg;

  typedef enum logic {
    BS_EMPTY = 1'b0,
    BS_FULL  = 1'b1
  } bshift_state_t;

  function automatic int sw_f(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bshift_rr_arb.sv
// Single-grant arbiter for bshift_arb. With BSHIFT_ARB_RR_EN defined it is round-robin
// (ptr advances past each winner on en); otherwise fixed priority, lowest index wins.
module bshift_rr_arb
  import bshift_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] base;
  logic          found;

`ifdef BSHIFT_ARB_RR_EN
  logic [IW-1:0] ptr;

  // Only a completed handshake moves the pointer, so a stalled grant stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign base = ptr;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, en};
  assign base      = '0;
`endif

  // Scan from base upward with wrap; fixed priority is the base == 0 case.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(base) + k) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = IW'((int'(base) + k) % NREQ);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/lbshift.sv
// Combinational left barrel shifter: result = data << amt, zero fill.
module lbshift #(
  parameter int  WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    amt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] stage;

  // One conditional stage per amount bit, shifting by 1, 2, 4, ...
  always_comb begin
    stage = data;
    for (int s = 0; s < SW; s++) begin
      if (amt[s]) stage = stage << (1 << s);
    end
    result = stage;
  end

endmodule

// File: rtl/bshift_arb.sv
// Shares one lbshift among NREQ valid/ready requesters and registers the winner's result.
// BSHIFT_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority.
module bshift_arb
  import bshift_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  NREQ  = 4,
  localparam int SW    = sw_f(WIDTH),
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*SW-1:0]    req_amt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IW-1:0]         rsp_id,
  output logic                  fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // requesters hold valid/data/amt until ready, and rsp_* holds while rsp_valid && !rsp_ready.

  bshift_state_t    state_q, state_d;
  logic             accept_ok;
  logic             hs;
  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    sel_amt;
  logic [WIDTH-1:0] shifted;

  bshift_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_amt  = req_amt[int'(gnt_idx)*SW +: SW];

  lbshift #(.WIDTH(WIDTH)) u_shift (
    .data   (sel_data),
    .amt    (sel_amt),
    .result (shifted)
  );

  // rst_n gates acceptance so nothing handshakes while reset is held.
  assign accept_ok = rst_n && ((state_q == BS_EMPTY) || rsp_ready);
  assign req_ready = accept_ok ? gnt : '0;
  assign hs        = accept_ok && (|req_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BS_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BS_EMPTY: if (hs) state_d = BS_FULL;
      BS_FULL: begin
        if (hs)             state_d = BS_FULL;
        else if (rsp_ready) state_d = BS_EMPTY;
      end
      default: state_d = BS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (hs) begin
      rsp_data <= shifted;
      rsp_id   <= gnt_idx;
    end
  end

  assign rsp_valid = (state_q == BS_FULL);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_bshift_arb.sv
// Directed bench for bshift_arb: reset, single request, backpressure, sweep, fairness, mid reset.
module tb_bshift_arb;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic [N*SW-1:0] req_amt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  bshift_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input logic [SW-1:0] a);
    req_data[i*W +: W] = d;
    req_amt[i*SW +: SW] = a;
  endtask

  // Retire every still-valid request, dropping each one once it is accepted.
  task automatic drain();
    logic [N-1:0] g;
    int budget;
    budget = 20;
    while (req_valid != '0 && budget > 0) begin
      #1;
      g = req_ready;
      next_cycle();
      req_valid = req_valid & ~g;
      budget--;
    end
    chk("drain_done", 32'(req_valid), 32'h0);
  endtask

  // Requester-side protocol rules: valid and payload hold until accepted.
  logic [N-1:0]    pend;
  logic [N*W-1:0]  prev_data;
  logic [N*SW-1:0] prev_amt;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          chk($sformatf("hold_valid%0d", i), 32'(req_valid[i]), 32'h1);
          chk($sformatf("hold_data%0d", i), 32'(req_data[i*W +: W]), 32'(prev_data[i*W +: W]));
          chk($sformatf("hold_amt%0d", i), 32'(req_amt[i*SW +: SW]), 32'(prev_amt[i*SW +: SW]));
        end
      end
      pend      <= req_valid & ~req_ready;
      prev_data <= req_data;
      prev_amt  <= req_amt;
    end
  end

  logic [W-1:0] exp_d;
  int           exp_g;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'h0);
    next_cycle();
    next_cycle();
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request
    next_cycle();
    set_req(2, 16'h00FF, 4'd2);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    next_cycle();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_data", 32'(rsp_data), 32'h03FC);
    chk("single_id", 32'(rsp_id), 32'h2);
    next_cycle();
    chk("single_pulse_end", 32'(rsp_valid), 32'h0);
    chk("single_data_hold", 32'(rsp_data), 32'h03FC);

    // Backpressure
    set_req(1, 16'hF00B, 4'd4);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready_empty", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    chk("bp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_data", 32'(rsp_data), 32'h00B0);
    chk("bp_id", 32'(rsp_id), 32'h1);
    set_req(3, 16'h0003, 4'd1);
    req_valid = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      next_cycle();
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", 32'(rsp_data), 32'h00B0);
      chk("bp_hold_id", 32'(rsp_id), 32'h1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    next_cycle();
    req_valid = '0;
    chk("bp_new_valid", 32'(rsp_valid), 32'h1);
    chk("bp_new_data", 32'(rsp_data), 32'h0006);
    chk("bp_new_id", 32'(rsp_id), 32'h3);
    next_cycle();
    chk("bp_drained", 32'(rsp_valid), 32'h0);
    chk("bp_drained_data", 32'(rsp_data), 32'h0006);

    // Sweep of amounts, back to back
    req_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      set_req(0, 16'h0001, 4'(k));
      #1;
      chk("sweep_ready", 32'(req_ready), 32'h1);
      next_cycle();
      chk("sweep_valid", 32'(rsp_valid), 32'h1);
      chk($sformatf("sweep_data_amt%0d", k), 32'(rsp_data), 32'h1 << k);
      chk("sweep_id", 32'(rsp_id), 32'h0);
    end
    req_valid = '0;
    next_cycle();
    chk("sweep_end", 32'(rsp_valid), 32'h0);

    // Fresh reset, then fairness with all four requesters valid
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    set_req(0, 16'h1111, 4'd0);
    set_req(1, 16'h2222, 4'd1);
    set_req(2, 16'h3333, 4'd2);
    set_req(3, 16'h4444, 4'd3);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifdef BSHIFT_ARB_RR_EN
      exp_g = k % 4;
`else
      exp_g = 0;
`endif
      case (exp_g)
        0:       exp_d = 16'h1111;
        1:       exp_d = 16'h4444;
        2:       exp_d = 16'hCCCC;
        default: exp_d = 16'h2220;
      endcase
      #1;
      chk($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'h1 << exp_g);
      next_cycle();
      chk($sformatf("fair_id_%0d", k), 32'(rsp_id), 32'(exp_g));
      chk($sformatf("fair_data_%0d", k), 32'(rsp_data), 32'(exp_d));
    end
    drain();
    next_cycle();
    chk("fair_end", 32'(rsp_valid), 32'h0);

    // Reset while a result is pending
    set_req(2, 16'h0100, 4'd4);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    next_cycle();
    req_valid = '0;
    chk("mid_pending_valid", 32'(rsp_valid), 32'h1);
    chk("mid_pending_data", 32'(rsp_data), 32'h1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    chk("mid_rst_state", 32'(fsm_state), 32'h0);
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("mid_first_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid[0] = 1'b0;
    chk("mid_first_id", 32'(rsp_id), 32'h0);
    chk("mid_first_data", 32'(rsp_data), 32'h1111);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
